// File: rtl/dircc_mem_master_pkg.sv
// Shared types for the DiRCC node memory master: command opcodes, FSM states and
// opcode decode helpers.
package dircc_mem_master_pkg;

    localparam int unsigned MemWordsDflt = 5120;

    typedef enum logic [1:0] {
        OpFill     = 2'd0,
        OpCheck    = 2'd1,
        OpFillInc  = 2'd2,
        OpCheckInc = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    function automatic logic is_check(input logic [1:0] op);
        return (op == OpCheck) || (op == OpCheckInc);
    endfunction

    function automatic logic is_inc(input logic [1:0] op);
        return (op == OpFillInc) || (op == OpCheckInc);
    endfunction

endpackage

// File: rtl/dircc_mem_cmp_tracker.sv
// Read-back compare tracker: saturating mismatch counter plus capture of the
// address and data of the first mismatch since the last clear.
module dircc_mem_cmp_tracker #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              clear_i,
    input  logic              cmp_valid_i,
    input  logic [ADDR_W-1:0] cmp_addr_i,
    input  logic [DATA_W-1:0] exp_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [ADDR_W:0]   err_count_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    output logic [DATA_W-1:0] first_err_data_o
);

    logic [ADDR_W:0]   err_count_q, err_count_d;
    logic [ADDR_W-1:0] first_addr_q, first_addr_d;
    logic [DATA_W-1:0] first_data_q, first_data_d;
    logic              mismatch;

    assign mismatch = cmp_valid_i && (rdata_i != exp_i);

    always_comb begin
        err_count_d  = err_count_q;
        first_addr_d = first_addr_q;
        first_data_d = first_data_q;
        if (clear_i) begin
            err_count_d  = '0;
            first_addr_d = '0;
            first_data_d = '0;
        end else if (mismatch) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
            if (err_count_q == '0) begin
                first_addr_d = cmp_addr_i;
                first_data_d = rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            err_count_q  <= '0;
            first_addr_q <= '0;
            first_data_q <= '0;
        end else begin
            err_count_q  <= err_count_d;
            first_addr_q <= first_addr_d;
            first_data_q <= first_data_d;
        end
    end

    assign err_count_o      = err_count_q;
    assign first_err_addr_o = first_addr_q;
    assign first_err_data_o = first_data_q;

endmodule

// File: rtl/dircc_node_mem_master.sv
// Avalon-MM block master for the DiRCC node memory: fills a word range with a
// constant/incrementing pattern, or reads it back and counts mismatches.
module dircc_node_mem_master
    import dircc_mem_master_pkg::*;
#(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_WORDS = MemWordsDflt
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_W-1:0]     cmd_base_i,
    input  logic [ADDR_W:0]       cmd_len_i,
    input  logic [DATA_W-1:0]     cmd_pattern_i,
    input  logic                  stall_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  range_err_o,
    output logic [ADDR_W:0]       err_count_o,
    output logic [ADDR_W-1:0]     first_err_addr_o,
    output logic [DATA_W-1:0]     first_err_data_o,
    output logic [ADDR_W-1:0]     avm_address_o,
    output logic [DATA_W/8-1:0]   avm_byteenable_o,
    output logic                  avm_chipselect_o,
    output logic                  avm_write_o,
    output logic [DATA_W-1:0]     avm_writedata_o,
    output logic                  avm_clken_o,
    input  logic [DATA_W-1:0]     avm_readdata_i
);

    localparam int unsigned LenW = ADDR_W + 1;
    localparam int unsigned BeW  = DATA_W / 8;

    state_e            state_q, state_d;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] base_q;
    logic [LenW-1:0]   len_q;
    logic [DATA_W-1:0] pattern_q;
    logic [LenW-1:0]   idx_q, idx_d;
    logic              range_err_q;
    logic              cmp_valid_q;
    logic [ADDR_W-1:0] cmp_addr_q;
    logic [DATA_W-1:0] cmp_exp_q;

    logic              accept;
    logic [LenW:0]     cmd_end;
    logic              cmd_oob;
    logic              issue;
    logic              last;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] exp_word;

    assign cmd_ready_o = (state_q == StIdle) && reset_ni;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign cmd_end     = {2'b00, cmd_base_i} + {1'b0, cmd_len_i};
    assign cmd_oob     = cmd_end > (LenW + 1)'(MEM_WORDS);
    assign issue       = (state_q == StRun) && !stall_i;
    assign last        = idx_q == (len_q - LenW'(1));
    assign cur_addr    = base_q + ADDR_W'(idx_q);
    assign exp_word    = pattern_q + (is_inc(op_q) ? DATA_W'(idx_q) : '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    idx_d = '0;
                    // Out-of-range and empty commands finish without touching the bus.
                    if (cmd_oob || (cmd_len_i == '0)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (!stall_i) begin
                    idx_d = idx_q + LenW'(1);
                    if (last) begin
                        state_d = is_check(op_q) ? StDrain : StDone;
                    end
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            op_q        <= '0;
            base_q      <= '0;
            len_q       <= '0;
            pattern_q   <= '0;
            idx_q       <= '0;
            range_err_q <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_exp_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cmp_valid_q <= issue && is_check(op_q);
            if (accept) begin
                op_q        <= cmd_op_i;
                base_q      <= cmd_base_i;
                len_q       <= cmd_len_i;
                pattern_q   <= cmd_pattern_i;
                range_err_q <= cmd_oob;
            end
            // Memory returns q one cycle after the read edge; keep what it should match.
            if (issue) begin
                cmp_addr_q <= cur_addr;
                cmp_exp_q  <= exp_word;
            end
        end
    end

    dircc_mem_cmp_tracker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp_tracker (
        .clk_i            (clk_i),
        .reset_ni         (reset_ni),
        .clear_i          (accept),
        .cmp_valid_i      (cmp_valid_q),
        .cmp_addr_i       (cmp_addr_q),
        .exp_i            (cmp_exp_q),
        .rdata_i          (avm_readdata_i),
        .err_count_o      (err_count_o),
        .first_err_addr_o (first_err_addr_o),
        .first_err_data_o (first_err_data_o)
    );

    assign busy_o           = state_q != StIdle;
    assign done_o           = state_q == StDone;
    assign range_err_o      = range_err_q;
    assign avm_chipselect_o = state_q == StRun;
    assign avm_write_o      = avm_chipselect_o && !is_check(op_q);
    assign avm_address_o    = avm_chipselect_o ? cur_addr : '0;
    assign avm_writedata_o  = avm_write_o ? exp_word : '0;
    assign avm_byteenable_o = {BeW{avm_chipselect_o}};
    assign avm_clken_o      = !stall_i && reset_ni;

endmodule

// File: doc/dircc_node_mem_master.md
# dircc_node_mem_master

Avalon-MM master that drives the DiRCC node's single-port on-chip memory slave (13-bit word address, 32-bit data, 4-bit byteenable, 1-cycle read latency, no waitrequest). It executes one block command at a time: fill a word range with a constant or incrementing pattern, or read a range back and check it against that pattern. It sits between the node's test/boot controller and the node memory. Typical uses are memory initialisation and scrub checking.

## Interface
Parameters:
- ADDR_W, 13, word address width
- DATA_W, 32, data width (byteenable width = DATA_W/8)
- MEM_WORDS, 5120, highest legal end address + 1

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=FILL, 1=CHECK, 2=FILL_INC, 3=CHECK_INC
- cmd_base  in  ADDR_W  first word address
- cmd_len  in  ADDR_W+1  word count, 0..MEM_WORDS
- cmd_pattern  in  DATA_W  seed pattern
- stall  in  1  freeze bus progress
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- range_err  out  1  cmd_base+cmd_len > MEM_WORDS; sticky until next accept
- err_count  out  ADDR_W+1  CHECK mismatches, saturating
- first_err_addr  out  ADDR_W  address of first mismatch
- first_err_data  out  DATA_W  read data at first mismatch
- avm_address  out  ADDR_W  to memory address
- avm_byteenable  out  DATA_W/8  constant all-ones while chipselect is high, else 0
- avm_chipselect, avm_write  out  1  bus strobes
- avm_writedata  out  DATA_W  write data
- avm_clken  out  1  equals ~stall
- avm_readdata  in  DATA_W  memory output, valid 1 cycle after a read edge

## Operation
- Reset values: cmd_ready=0 during reset and 1 after; all other outputs 0.
- Accept a command on a clk edge where cmd_valid & cmd_ready. Latch op, base, len and pattern. Clear err_count, first_err_*, range_err.
- Expected word i = pattern for FILL/CHECK, and pattern+i mod 2^DATA_W for the _INC ops.
- Range check at accept: if base+len > MEM_WORDS, set range_err, issue no bus cycles, pulse done at the next cycle.
- len=0: no bus cycles; done at the next cycle.
- States:
  - IDLE → RUN on accept.
  - RUN issues one word per unstalled cycle at address base+i.
  - RUN → DRAIN after the last issue for CHECK ops.
  - RUN → DONE after the last issue for FILL ops.
  - DRAIN performs the final compare → DONE.
  - DONE pulses done → IDLE.
- FILL: chipselect=write=1, writedata = expected word i.
- CHECK: chipselect=1, write=0. The compare of word i happens in the cycle after its issue edge and uses the registered address/expected value.
- Mismatch: increment err_count, saturating at all-ones. On the first mismatch only, capture the address and read data.
- Stall: avm_clken=0. The master holds address, writedata and strobes stable; index i does not advance. A compare pending from an earlier unstalled edge still completes, because the memory holds q while clken is low.
- busy = state != IDLE.
- Async reset mid-command aborts immediately. No done pulse. Memory contents are left partial.

## Timing
- Accept at edge T. First bus cycle is the cycle after T.
- FILL, no stall: writes occupy cycles T+1..T+len; done is high in cycle T+len+1.
- CHECK, no stall: reads are issued in T+1..T+len; last compare in T+len+1; done in T+len+2. err_count is final when done is high.
- Each stall cycle adds exactly one cycle of latency.
- cmd_ready rises in the cycle after done.

## Structure
- Package dircc_mem_master_pkg holds:
  - op encoding enum;
  - state enum (IDLE, RUN, DRAIN, DONE);
  - MEM_WORDS default;
  - an is_check(op)/is_inc(op) helper.
- Sub-module dircc_mem_cmp_tracker: compare-valid, expected and readdata in; saturating err_count and first-error capture out; cleared on accept.

## Test plan
- FILL base=0x100, len=4, pattern=0xA5A5A5A5 → writes at 0x100..0x103 in 4 consecutive cycles, byteenable=0xF, done at T+5.
- FILL_INC base=0, len=3, pattern=0xFFFFFFFF → writedata 0xFFFFFFFF, 0x00000000, 0x00000001 (wraps).
- CHECK_INC over a model with word 0x102 corrupted to 0 → err_count=1, first_err_addr=0x102, first_err_data=0, done at T+len+2.
- base=5118, len=3 → range_err=1, no chipselect, done at T+1. len=0 → done at T+1, range_err=0.
- CHECK len=4 with stall held for 3 cycles after the 2nd read → outputs held stable, clken=0, done at T+9, err_count=0 on a clean model.
- reset_n low during RUN → all outputs 0 asynchronously. After release, cmd_ready=1 and a new command runs normally.
